// File: rtl/zero_run_pkg.sv
// Purpose: shared types and helpers for the zero-run token decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package zero_run_pkg;

    // Widest word any instance is expected to rebuild; sizes the token struct.
    localparam int ZR_MAX_W  = 256;
    localparam int ZR_MAX_CW = $clog2(ZR_MAX_W) + 1;

    // Output stage occupancy: EMPTY_OUT holds nothing, FULL_OUT holds a word.
    localparam logic [0:0] ZR_EMPTY_OUT = 1'b0;
    localparam logic [0:0] ZR_FULL_OUT  = 1'b1;

    // Token count width: one more bit than a bit index so that a count equal
    // to the full word width is representable.
    function automatic int zr_cw(input int dw);
        return $clog2(dw) + 1;
    endfunction

    // Bit i of the one-hot for run end position s. Positions at or past the
    // word width produce no bit, so an exactly-full run sets nothing.
    function automatic logic zr_onehot(input int s, input int i, input int dw);
        return (i == s) && (s < dw);
    endfunction

    // One token: "count zeros, then a one"; last closes the current word.
    typedef struct packed {
        logic [ZR_MAX_CW-1:0] count;
        logic                 last;
    } zr_token_t;

endpackage

// File: rtl/zero_run_place.sv
// Purpose: places one zero-run token into the partial word (pure combinational).
// Latency: 0 cycles.
// Backpressure: none; the caller decides when the result is committed.
//
// Ports:
//   acc      - partial word built so far
//   pos      - next free bit position
//   count    - zero-run length of the incoming token
//   acc_next - partial word with this token's one-bit placed (if it fits)
//   pos_next - position after this token (meaningful only when !full)
//   trunc    - run ran past the MSB, bits were lost
//   full     - no free position remains after this token
module zero_run_place
    import zero_run_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CW         = zr_cw(DATA_WIDTH),
    localparam int PW         = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [PW-1:0]         pos,
    input  logic [CW-1:0]         count,
    output logic [DATA_WIDTH-1:0] acc_next,
    output logic [PW-1:0]         pos_next,
    output logic                  trunc,
    output logic                  full
);

    localparam logic [CW:0] DW_S = (CW+1)'(DATA_WIDTH);

    // End-of-run position, one bit wider than the count so it never wraps.
    logic [CW:0] s;

    always_comb begin
        s        = (CW+1)'(pos) + (CW+1)'(count);
        trunc    = (s > DW_S);
        full     = ((s + (CW+1)'(1)) >= DW_S);
        // Only consumed when !full, i.e. s+1 < DATA_WIDTH, so the narrow
        // add cannot overflow in the cases that matter.
        pos_next = pos + count[PW-1:0] + PW'(1);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            acc_next[i] = acc[i] | zr_onehot(int'(s), i, DATA_WIDTH);
        end
    end

endmodule

// File: rtl/zero_run_decoder.sv
// Purpose: rebuilds DATA_WIDTH-bit words, LSB first, from zero-run tokens.
// Latency: word registered on the edge that accepts its closing token.
// Backpressure: in_ready = !out_valid || out_ready; full rate when unstalled.
//
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   in_valid/in_ready    - token handshake; in_count = run length, in_last closes word
//   out_valid/out_ready  - word handshake; dout = word, out_trunc = bits lost past MSB
module zero_run_decoder
    import zero_run_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int CW         = zr_cw(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW-1:0]         in_count,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  out_trunc
);

    localparam int PW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] acc;
    logic [PW-1:0]         pos;
    logic                  trunc_acc;
    logic [0:0]            out_state;

    logic [DATA_WIDTH-1:0] acc_next;
    logic [PW-1:0]         pos_next;
    logic                  tok_trunc;
    logic                  tok_full;
    logic                  accept;
    logic                  complete;

    zero_run_place #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_place (
        .acc      (acc),
        .pos      (pos),
        .count    (in_count),
        .acc_next (acc_next),
        .pos_next (pos_next),
        .trunc    (tok_trunc),
        .full     (tok_full)
    );

    assign out_valid = (out_state == ZR_FULL_OUT);
    // Only combinational input-to-output path in the block.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign complete  = accept && (in_last || tok_full);

    // Accumulator: a completing token clears state on the same edge that
    // hands the finished word to the output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc       <= '0;
            pos       <= '0;
            trunc_acc <= 1'b0;
        end else if (accept) begin
            if (complete) begin
                acc       <= '0;
                pos       <= '0;
                trunc_acc <= 1'b0;
            end else begin
                acc       <= acc_next;
                pos       <= pos_next;
                trunc_acc <= trunc_acc | tok_trunc;
            end
        end
    end

    // Output stage. A completion can only happen while in_ready is high, so
    // a stalled word is never overwritten; completion during a drain reloads
    // the register and keeps FULL_OUT for back-to-back words.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_state <= ZR_EMPTY_OUT;
            dout      <= '0;
            out_trunc <= 1'b0;
        end else if (complete) begin
            out_state <= ZR_FULL_OUT;
            dout      <= acc_next;
            out_trunc <= trunc_acc | tok_trunc;
        end else if (out_valid && out_ready) begin
            out_state <= ZR_EMPTY_OUT;
        end
    end

endmodule

// File: tb/tb_zero_run_decoder.sv
// Purpose: self-checking bench for zero_run_decoder at DATA_WIDTH=8.
// Latency: n/a.
// Backpressure: exercises output stalls and back-to-back completion.
module tb_zero_run_decoder;
    import zero_run_pkg::*;

    localparam int DW = 8;
    localparam int CW = zr_cw(DW);

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_count;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout;
    logic          out_trunc;

    always #5 clk = ~clk;

    zero_run_decoder #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_trunc (out_trunc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words are rebuilt from the token rules directly: a bit position counter
    // and a word value, with finished words queued in order of completion.
    typedef struct {
        logic [DW-1:0] w;
        bit            t;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    int            mpos;
    logic [DW-1:0] mword;
    bit            mtrunc;
    int            ms;

    task automatic model_clear();
        mpos   = 0;
        mword  = '0;
        mtrunc = 1'b0;
        exp_q.delete();
    endtask

    // Single compare process: everything sampled on the falling edge, the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got 0x%0h, expected no word at %0t", dout, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_dout", 32'(dout), 32'(e.w));
                    chk("word_trunc", 32'(out_trunc), 32'(e.t));
                end
            end
            if (in_valid && in_ready) begin
                ms = mpos + int'(in_count);
                if (ms < DW) mword = mword | (DW'(1) << ms);
                if (ms > DW) mtrunc = 1'b1;
                if (in_last || (ms + 1 >= DW)) begin
                    e.w = mword;
                    e.t = mtrunc;
                    exp_q.push_back(e);
                    mpos   = 0;
                    mword  = '0;
                    mtrunc = 1'b0;
                end else begin
                    mpos = ms + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input int c, input bit last);
        zr_token_t tok;
        int        n;
        bit        ok;
        tok       = '0;
        tok.count = ZR_MAX_CW'(c);
        tok.last  = last;
        in_valid  = 1'b1;
        in_count  = tok.count[CW-1:0];
        in_last   = tok.last;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: token (%0d,%0d) not accepted within 50 cycles", c, last);
        end
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges so its effect is visibly asynchronous.
    task automatic async_reset(input string tag);
        #3;
        resetn = 1'b0;
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_dout"}, 32'(dout), 32'h0);
        chk({tag, "_out_trunc"}, 32'(out_trunc), 32'h0);
        model_clear();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();
        tick(2);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_out_trunc", 32'(out_trunc), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        resetn = 1'b1;
        tick(1);

        // 1: two tokens -> bits 2 and 5; valid right after the closing accept
        send(2, 1'b0);
        chk("t1_not_yet_valid", 32'(out_valid), 32'h0);
        send(2, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_dout", 32'(dout), 32'h24);
        chk("t1_trunc", 32'(out_trunc), 32'h0);
        tick(1);

        // 2: exactly-full run gives zero word; zero run gives bit 0
        send(8, 1'b1);
        chk("t2a_dout", 32'(dout), 32'h00);
        chk("t2a_trunc", 32'(out_trunc), 32'h0);
        send(0, 1'b1);
        chk("t2b_dout", 32'(dout), 32'h01);
        tick(1);

        // 3: eight zero-length runs fill the word without in_last
        for (int i = 0; i < 8; i++) send(0, 1'b0);
        chk("t3_valid", 32'(out_valid), 32'h1);
        chk("t3_dout", 32'(dout), 32'hFF);
        chk("t3_trunc", 32'(out_trunc), 32'h0);
        tick(1);

        // 4: second run overflows past the MSB
        send(5, 1'b0);
        send(4, 1'b0);
        chk("t4_dout", 32'(dout), 32'h20);
        chk("t4_trunc", 32'(out_trunc), 32'h1);
        tick(1);

        // 5: stalled output, next closing token waiting, then release
        out_ready = 1'b0;
        send(1, 1'b1);
        in_valid = 1'b1;
        in_count = CW'(3);
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_stall_in_ready", 32'(in_ready), 32'h0);
            chk("t5_stall_dout", 32'(dout), 32'h02);
            chk("t5_stall_valid", 32'(out_valid), 32'h1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t5_b2b_valid", 32'(out_valid), 32'h1);
        chk("t5_b2b_dout", 32'(dout), 32'h08);
        tick(1);
        chk("t5_drained", 32'(out_valid), 32'h0);

        // 6: reset mid-word (pos=3), then with a stalled word pending
        send(0, 1'b0);
        send(0, 1'b0);
        send(0, 1'b0);
        async_reset("t6a");
        send(0, 1'b1);
        chk("t6a_restart_dout", 32'(dout), 32'h01);
        tick(1);
        out_ready = 1'b0;
        send(2, 1'b1);
        chk("t6b_pending_dout", 32'(dout), 32'h04);
        async_reset("t6b");
        out_ready = 1'b1;
        send(1, 1'b0);
        send(2, 1'b1);
        chk("t6b_restart_dout", 32'(dout), 32'h12);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
